// File: rtl/mac_pkg.sv
// Shared definitions for the MAC controller: state encoding, default tap count
// and the tap-index width rule.
package mac_pkg;

  localparam int DEFAULT_N_TAPS = 9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_ACCUM = 2'd2;
  localparam state_t ST_VALID = 2'd3;

  // A single-tap configuration still needs a one-bit index.
  function automatic int cnt_width(input int n_taps);
    return (n_taps > 1) ? $clog2(n_taps) : 1;
  endfunction

endpackage

// File: rtl/mac_ctrl_if.sv
// Control/handshake bundle between the MAC controller and its surroundings.
// in_valid has no back-pressure: a product is consumed in any ACCUM cycle where
// it is high (acc_en mirrors that). out_valid/out_ready: the result transfers
// on a cycle where both are high, and out_valid holds until that cycle.
interface mac_ctrl_if
  import mac_pkg::*;
#(
  parameter int CNT_WIDTH = cnt_width(DEFAULT_N_TAPS)
);
  logic                 start;
  logic                 in_valid;
  logic                 out_ready;
  logic                 sel_acc;
  logic                 acc_en;
  logic [CNT_WIDTH-1:0] tap_idx;
  logic                 busy;
  logic                 out_valid;
  logic                 done;

  modport master (
    input  start, in_valid, out_ready,
    output sel_acc, acc_en, tap_idx, busy, out_valid, done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  sel_acc, acc_en, tap_idx, busy, out_valid, done
  );
endinterface

// File: rtl/mac_tap_counter.sv
// Tap index counter: cleared at the start of a run, advanced per accepted
// product, and folded back to zero after the last tap.
module mac_tap_counter #(
  parameter int N_TAPS    = 9,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 last
);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N_TAPS - 1);

  assign last = (count == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/mac_ctrl.sv
// Sequencer for a multiply-accumulate datapath: clears the accumulator, steps
// through N_TAPS products (legal range 1..256), then holds the result until
// the downstream stage takes it.
module mac_ctrl
  import mac_pkg::*;
#(
  parameter int N_TAPS    = DEFAULT_N_TAPS,
  parameter int CNT_WIDTH = cnt_width(N_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_ctrl_if.master        bus,
  output state_t            state_dbg
);
  state_t               state_q;
  state_t               state_d;
  logic                 done_q;
  logic                 tap_clr;
  logic                 tap_en;
  logic                 tap_last;
  logic [CNT_WIDTH-1:0] tap_count;

  assign tap_clr = (state_q == ST_CLEAR);
  assign tap_en  = (state_q == ST_ACCUM) && bus.in_valid;

  mac_tap_counter #(
    .N_TAPS    (N_TAPS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_tap_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tap_clr),
    .en    (tap_en),
    .count (tap_count),
    .last  (tap_last)
  );

  // start is only looked at in IDLE and in the handshake cycle, so a start
  // seen anywhere else in a run is dropped rather than remembered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_ACCUM;
      ST_ACCUM: if (bus.in_valid && tap_last) state_d = ST_VALID;
      ST_VALID: if (bus.out_ready) state_d = bus.start ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_VALID) && bus.out_ready;
    end
  end

  // Everything below is decoded from state; acc_en in ACCUM is the one
  // output that follows in_valid within the cycle.
  assign bus.sel_acc   = (state_q == ST_ACCUM) || (state_q == ST_VALID);
  assign bus.acc_en    = (state_q == ST_CLEAR) || tap_en;
  assign bus.tap_idx   = tap_count;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = (state_q == ST_VALID);
  assign bus.done      = done_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_mac_ctrl.sv
// Bench for mac_ctrl: a 9-tap and a 1-tap instance, each driving a small
// accumulator model whose final value is checked against the driven products.
module tb_mac_ctrl;
  import mac_pkg::*;

  localparam int CW9 = cnt_width(9);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_ctrl_if #(.CNT_WIDTH(CW9)) bus9 ();
  mac_ctrl_if #(.CNT_WIDTH(1))   bus1 ();
  state_t st9;
  state_t st1;

  mac_ctrl #(.N_TAPS(9)) dut9 (.clk(clk), .rst_n(rst_n), .bus(bus9), .state_dbg(st9));
  mac_ctrl #(.N_TAPS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(st1));

  // accumulator datapath models steered by the controller outputs
  logic [15:0] prod9, prod1;
  logic [31:0] acc9, acc1;
  always_ff @(posedge clk) begin
    if (bus9.acc_en) acc9 <= bus9.sel_acc ? acc9 + 32'(prod9) : 32'd0;
    if (bus1.acc_en) acc1 <= bus1.sel_acc ? acc1 + 32'(prod1) : 32'd0;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {state, busy, sel_acc, acc_en, out_valid, done, tap_idx}
  function automatic logic [12:0] pk(state_t s, logic b, logic sa, logic en,
                                     logic ov, logic dn, logic [3:0] t);
    return {s, b, sa, en, ov, dn, t};
  endfunction

  function automatic logic [12:0] obs9();
    return pk(st9, bus9.busy, bus9.sel_acc, bus9.acc_en, bus9.out_valid, bus9.done,
              4'(bus9.tap_idx));
  endfunction

  function automatic logic [12:0] obs1();
    return pk(st1, bus1.busy, bus1.sel_acc, bus1.acc_en, bus1.out_valid, bus1.done,
              {3'b000, bus1.tap_idx});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One 9-tap run. mask bit t inserts a stall cycle before tap t; rwait is the
  // number of out_ready=0 cycles in VALID; noise drives random start while busy.
  // started=1 means the previous run chained and we are already in CLEAR.
  task automatic do_run(input logic [8:0] mask, input int rwait, input bit noise,
                        input bit chain, input bit started, input int exp_lat,
                        input string tag);
    int c;
    logic [31:0] sum;
    logic [31:0] snap;
    sum = 0;
    if (!started) begin
      cyc();
      bus9.start = 1'b1; bus9.in_valid = 1'b0; bus9.out_ready = 1'b0;
      #1 chk({tag, " idle"}, 32'(obs9()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 0, 4'd0)));
      cyc();
    end
    c = 1;
    bus9.start = noise ? rnd_bit() : 1'b0;
    bus9.in_valid = 1'b1; bus9.out_ready = 1'b0;
    prod9 = 16'($urandom_range(0, 65535));
    #1 chk({tag, " clear"}, 32'(obs9()), 32'(pk(ST_CLEAR, 1, 0, 1, 0, started, 4'd0)));
    for (int t = 0; t < 9; t++) begin
      if (mask[t]) begin
        cyc(); c++;
        bus9.in_valid = 1'b0;
        bus9.start = noise ? rnd_bit() : 1'b0;
        #1 chk({tag, " stall"}, 32'(obs9()), 32'(pk(ST_ACCUM, 1, 1, 0, 0, 0, 4'(t))));
      end
      cyc(); c++;
      bus9.in_valid = 1'b1;
      bus9.start = noise ? rnd_bit() : 1'b0;
      prod9 = 16'($urandom_range(0, 65535));
      sum += 32'(prod9);
      #1 chk({tag, " tap"}, 32'(obs9()), 32'(pk(ST_ACCUM, 1, 1, 1, 0, 0, 4'(t))));
    end
    exp_q.push_back(sum);
    cyc(); c++;
    chk({tag, " latency"}, 32'(c), 32'(exp_lat));
    snap = acc9;
    for (int w = 0; w <= rwait; w++) begin
      if (w > 0) cyc();
      bus9.in_valid = rnd_bit();
      bus9.out_ready = (w == rwait);
      bus9.start = (w == rwait) ? chain : (noise ? rnd_bit() : 1'b0);
      #1 chk({tag, " valid"}, 32'(obs9()), 32'(pk(ST_VALID, 1, 1, 0, 1, 0, 4'd0)));
      chk({tag, " acc hold"}, acc9, snap);
    end
    chk({tag, " sb depth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) chk({tag, " result"}, acc9, exp_q.pop_front());
    cyc();
    bus9.out_ready = 1'b0; bus9.start = 1'b0; bus9.in_valid = 1'b0;
    #1 chk({tag, " done"}, 32'(obs9()),
           32'(chain ? pk(ST_CLEAR, 1, 0, 1, 0, 1, 4'd0) : pk(ST_IDLE, 0, 0, 0, 0, 1, 4'd0)));
  endtask

  // One run on the single-tap instance, optionally with one stall cycle.
  task automatic run1(input bit stall, input string tag);
    int c;
    cyc();
    bus1.start = 1'b1; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    #1 chk({tag, " idle"}, 32'(obs1()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 0, 4'd0)));
    cyc(); c = 1;
    bus1.start = 1'b0;
    #1 chk({tag, " clear"}, 32'(obs1()), 32'(pk(ST_CLEAR, 1, 0, 1, 0, 0, 4'd0)));
    if (stall) begin
      cyc(); c++;
      bus1.in_valid = 1'b0;
      #1 chk({tag, " stall"}, 32'(obs1()), 32'(pk(ST_ACCUM, 1, 1, 0, 0, 0, 4'd0)));
    end
    cyc(); c++;
    bus1.in_valid = 1'b1;
    prod1 = 16'($urandom_range(0, 65535));
    exp_q.push_back(32'(prod1));
    #1 chk({tag, " accum"}, 32'(obs1()), 32'(pk(ST_ACCUM, 1, 1, 1, 0, 0, 4'd0)));
    cyc(); c++;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    #1 chk({tag, " latency"}, 32'(c), 32'(3 + int'(stall)));
    chk({tag, " valid"}, 32'(obs1()), 32'(pk(ST_VALID, 1, 1, 0, 1, 0, 4'd0)));
    if (exp_q.size() > 0) chk({tag, " result"}, acc1, exp_q.pop_front());
    cyc();
    bus1.out_ready = 1'b0;
    #1 chk({tag, " done"}, 32'(obs1()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 1, 4'd0)));
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [8:0] mask;
    int         rwait;
    bit         noise;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{mask: 9'h000, rwait: 0, noise: 1'b0, exp_lat: 11};
    vecs[1] = '{mask: 9'h088, rwait: 0, noise: 1'b0, exp_lat: 13};
    vecs[2] = '{mask: 9'h000, rwait: 5, noise: 1'b1, exp_lat: 11};
    vecs[3] = '{mask: 9'h101, rwait: 2, noise: 1'b1, exp_lat: 13};
    vecs[4] = '{mask: 9'h1FF, rwait: 1, noise: 1'b1, exp_lat: 20};

    bus9.start = 1'b1; bus9.in_valid = 1'b1; bus9.out_ready = 1'b1;
    bus1.start = 1'b1; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
    prod9 = '0; prod1 = '0;
    repeat (3) cyc();
    chk("reset 9", 32'(obs9()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 0, 4'd0)));
    chk("reset 1", 32'(obs1()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 0, 4'd0)));
    bus9.start = 1'b0; bus9.in_valid = 1'b0; bus9.out_ready = 1'b0;
    bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    chk("post reset", 32'(obs9()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 0, 4'd0)));

    for (int i = 0; i < 5; i++) begin
      do_run(vecs[i].mask, vecs[i].rwait, vecs[i].noise, 1'b0, 1'b0, vecs[i].exp_lat,
             $sformatf("vec%0d", i));
    end

    // start held through the handshake: back-to-back runs, no IDLE between
    do_run(9'h000, 1, 1'b0, 1'b1, 1'b0, 11, "chain a");
    do_run(9'h010, 0, 1'b0, 1'b0, 1'b1, 12, "chain b");

    // reset in the middle of tap 4
    cyc(); bus9.start = 1'b1;
    cyc(); bus9.start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      cyc();
      bus9.in_valid = 1'b1;
      prod9 = 16'($urandom_range(0, 65535));
    end
    #1 chk("pre abort", 32'(obs9()), 32'(pk(ST_ACCUM, 1, 1, 1, 0, 0, 4'd4)));
    #1 rst_n = 1'b0;
    #1 chk("abort async", 32'(obs9()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 0, 4'd0)));
    cyc();
    chk("abort hold", 32'(obs9()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 0, 4'd0)));
    bus9.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    chk("abort no done", 32'(obs9()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 0, 4'd0)));
    cyc();
    chk("abort waits", 32'(obs9()), 32'(pk(ST_IDLE, 0, 0, 0, 0, 0, 4'd0)));
    do_run(9'h020, 0, 1'b1, 1'b0, 1'b0, 12, "after abort");

    // single-tap configuration
    run1(1'b0, "n1 plain");
    run1(1'b1, "n1 stall");

    chk("sb empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time budget");
    $fatal(1, "watchdog");
  end
endmodule
